frame_mem_arbiter: RTL and testbench

- Shares the single-port 8-bit image frame memory (300x300 pixels, 18-bit address) between two requesters: the VGA pixel read path and the image-processing core, which reads and writes pixels.
- The VGA path has fixed priority. The processing core uses a req/gnt handshake and gets free cycles.
- A tag pipeline routes returning read data to the correct requester with constant latency.
- Out-of-image addresses are filtered out and never reach memory.

---
 rtl/frame_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_frame_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_arbiter.sv
// Arbiter for the single-port frame memory: VGA reads have fixed priority and the processing core gets the free cycles.
// Read data returns to its owner with constant latency. Optional macro STARVE_GUARD_EN bounds how long the core can wait.
module frame_mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int IMG_PIXELS = 90000,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_rvalid,
  output logic              proc_err,
  output logic              vga_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(IMG_PIXELS);

  if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1) begin : g_param_check
    $error("frame_mem_arbiter: RD_LAT must be 1..4 and STARVE_MAX at least 1");
  end

  typedef struct packed {
    logic valid;
    logic owner;  // 0 = VGA, 1 = processing core
    logic oob;
  } tag_t;

  logic vga_oob, proc_oob, sel_oob;
  logic starve, vga_win;
  tag_t tag_reg [RD_LAT+1];
  tag_t tag_next;
  tag_t head;

  assign vga_oob  = (vga_addr >= LIMIT);
  assign proc_oob = (proc_addr >= LIMIT);

`ifdef STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  logic [WAIT_W-1:0] wait_cnt_reg;

  // Saturating count of cycles the core has been kept waiting.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt_reg <= '0;
    else if (proc_gnt)
      wait_cnt_reg <= '0;
    else if (proc_req && wait_cnt_reg != WAIT_W'(STARVE_MAX))
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end

  assign starve    = proc_req && (wait_cnt_reg == WAIT_W'(STARVE_MAX));
  assign vga_stall = vga_req & starve;
`else
  assign starve    = 1'b0;
  assign vga_stall = 1'b0;
`endif

  assign vga_win  = vga_req & ~starve;
  assign proc_gnt = proc_req & ~vga_win;
  assign sel_oob  = vga_win ? vga_oob : proc_oob;

  // OOB reads still take a tag slot so the return latency never changes.
  always_comb begin
    tag_next       = '0;
    tag_next.valid = vga_win | (proc_gnt & ~proc_we);
    tag_next.owner = ~vga_win;
    tag_next.oob   = sel_oob;
  end

  assign head = tag_reg[RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      vga_valid   <= 1'b0;
      vga_data    <= '0;
      proc_rvalid <= 1'b0;
      proc_rdata  <= '0;
      proc_err    <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++)
        tag_reg[i] <= '0;
    end else begin
      mem_en    <= (vga_win | proc_gnt) & ~sel_oob;
      mem_we    <= proc_gnt & proc_we & ~sel_oob;
      mem_addr  <= vga_win ? vga_addr : proc_addr;
      mem_wdata <= proc_wdata;

      tag_reg[0] <= tag_next;
      for (int i = 1; i <= RD_LAT; i++)
        tag_reg[i] <= tag_reg[i-1];

      vga_valid   <= head.valid & ~head.owner;
      proc_rvalid <= head.valid & head.owner;
      if (head.valid && !head.owner)
        vga_data <= head.oob ? '0 : mem_rdata;
      if (head.valid && head.owner)
        proc_rdata <= head.oob ? '0 : mem_rdata;
      // Dropped writes flag immediately; dropped reads flag alongside their rvalid.
      proc_err <= (proc_gnt & proc_we & proc_oob) | (head.valid & head.owner & head.oob);
    end
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed self-checking bench for frame_mem_arbiter with a one-cycle-latency frame memory model.
// Build with STARVE_GUARD_EN defined to also exercise the starvation guard.
module tb_frame_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [17:0] vga_addr;
  logic [7:0]  vga_data;
  logic        vga_valid;
  logic        proc_req;
  logic        proc_we;
  logic [17:0] proc_addr;
  logic [7:0]  proc_wdata;
  logic        proc_gnt;
  logic [7:0]  proc_rdata;
  logic        proc_rvalid;
  logic        proc_err;
  logic        vga_stall;
  logic        mem_en;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(proc_gnt), .proc_rdata(proc_rdata), .proc_rvalid(proc_rvalid), .proc_err(proc_err),
    .vga_stall(vga_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Frame memory model: registered read, RD_LAT = 1.
  logic [7:0] mem_array [0:262143];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr];
    end
  end

  typedef struct {
    logic        is_vga;
    logic        we;
    logic [17:0] addr;
    logic [7:0]  wdata;
    logic        exp_en;
    logic        exp_err_wr;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_err_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next cycle; inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vga_req = 0; vga_addr = '0;
    proc_req = 0; proc_we = 0; proc_addr = '0; proc_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [17:0] addr, input logic [7:0] data);
    proc_req = 1; proc_we = 1; proc_addr = addr; proc_wdata = data;
    next_cycle();
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_vga_valid"}, 32'(vga_valid), 0);
    check({tag, "_vga_data"}, 32'(vga_data), 0);
    check({tag, "_proc_rvalid"}, 32'(proc_rvalid), 0);
    check({tag, "_proc_rdata"}, 32'(proc_rdata), 0);
    check({tag, "_proc_err"}, 32'(proc_err), 0);
    check({tag, "_vga_stall"}, 32'(vga_stall), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 18'h00064, 8'h00, 1'b1, 1'b0, 1'b1, 8'h74, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 18'd5,     8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 18'd5,     8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 18'd90000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 18'd90001, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 18'd90000, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 18'd89999, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 18'd0,     8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};

    // Reset then idle: everything quiet.
    do_reset();
    sample();
    check_all_zero("reset");
    check("reset_proc_gnt", 32'(proc_gnt), 0);
    $display("reset: outputs idle");

    next_cycle();
    preload(18'h00064, 8'h74);
    preload(18'd89999, 8'h3C);
    preload(18'd0, 8'h11);
    for (int k = 0; k < 4; k++) preload(18'(10 + k), 8'(8'h20 + k));
    next_cycle();

    // Single isolated transactions, checked at issue, +1 and +3 cycles.
    foreach (vecs[i]) begin
      if (vecs[i].is_vga) begin
        vga_req = 1; vga_addr = vecs[i].addr;
      end else begin
        proc_req = 1; proc_we = vecs[i].we; proc_addr = vecs[i].addr; proc_wdata = vecs[i].wdata;
      end
      sample();
      check($sformatf("v%0d_gnt", i), 32'(proc_gnt), 32'(!vecs[i].is_vga));
      next_cycle();
      idle_inputs();
      sample();
      check($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
        check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      end
      check($sformatf("v%0d_err_wr", i), 32'(proc_err), 32'(vecs[i].exp_err_wr));
      next_cycle();
      sample();
      check($sformatf("v%0d_early_valid", i), 32'(vga_valid | proc_rvalid), 0);
      next_cycle();
      sample();
      check($sformatf("v%0d_vga_valid", i), 32'(vga_valid), 32'(vecs[i].exp_valid & vecs[i].is_vga));
      check($sformatf("v%0d_proc_rvalid", i), 32'(proc_rvalid), 32'(vecs[i].exp_valid & !vecs[i].is_vga));
      if (vecs[i].exp_valid && vecs[i].is_vga)
        check($sformatf("v%0d_vga_data", i), 32'(vga_data), 32'(vecs[i].exp_data));
      if (vecs[i].exp_valid && !vecs[i].is_vga)
        check($sformatf("v%0d_proc_rdata", i), 32'(proc_rdata), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_err_rd", i), 32'(proc_err), 32'(vecs[i].exp_err_rd));
      $display("vec %0d: %s we=%0d addr=%0d done", i, vecs[i].is_vga ? "vga" : "proc", vecs[i].we, vecs[i].addr);
      next_cycle();
    end

    // Back-to-back processing-core write then read of the same pixel.
    proc_req = 1; proc_we = 1; proc_addr = 18'd7; proc_wdata = 8'h5A;
    sample();
    check("b2b_gnt_wr", 32'(proc_gnt), 1);
    next_cycle();
    proc_we = 0;
    sample();
    check("b2b_gnt_rd", 32'(proc_gnt), 1);
    next_cycle();
    idle_inputs();
    next_cycle();
    sample();
    check("b2b_early", 32'(proc_rvalid), 0);
    next_cycle();
    sample();
    check("b2b_rvalid", 32'(proc_rvalid), 1);
    check("b2b_rdata", 32'(proc_rdata), 32'h5A);
    $display("b2b: write/read addr 7 done");
    next_cycle();

    // Contention: both request for 4 cycles, then only the core.
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k < 5) begin
        proc_req = 1; proc_we = 0; proc_addr = 18'd12;
      end
      if (k < 4) begin
        vga_req = 1; vga_addr = 18'(10 + k);
      end
      sample();
      check($sformatf("cont%0d_gnt", k), 32'(proc_gnt), 32'(k == 4));
      check($sformatf("cont%0d_stall", k), 32'(vga_stall), 0);
      check($sformatf("cont%0d_mem_en", k), 32'(mem_en), 32'(k >= 1 && k <= 5));
      if (k == 5) check("cont_proc_addr", 32'(mem_addr), 12);
      check($sformatf("cont%0d_vga_valid", k), 32'(vga_valid), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6)
        check($sformatf("cont%0d_vga_data", k), 32'(vga_data), 32'(8'h20 + k - 3));
      check($sformatf("cont%0d_proc_rvalid", k), 32'(proc_rvalid), 32'(k == 7));
      if (k == 7) check("cont_proc_rdata", 32'(proc_rdata), 32'h22);
      next_cycle();
    end
    idle_inputs();
    $display("contention: 4 cycles of vga priority then proc grant done");

    // Reset with a VGA read in flight: nothing returns afterwards.
    vga_req = 1; vga_addr = 18'd0;
    next_cycle();
    idle_inputs();
    rst = 1;
    next_cycle();
    sample();
    check_all_zero("rst_inflight");
    next_cycle();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("rst_flush%0d", k), 32'(vga_valid | proc_rvalid), 0);
      next_cycle();
    end
    $display("reset: in-flight read discarded");

`ifdef STARVE_GUARD_EN
    do_reset();
    vga_req = 1; vga_addr = 18'd0;
    proc_req = 1; proc_we = 1; proc_addr = 18'd50; proc_wdata = 8'h01;
    for (int k = 0; k < 20; k++) begin
      sample();
      check($sformatf("starve%0d_gnt", k), 32'(proc_gnt), 32'(k == 16));
      check($sformatf("starve%0d_stall", k), 32'(vga_stall), 32'(k == 16));
      next_cycle();
      if (k == 16) proc_req = 0;
    end
    idle_inputs();
    $display("starve: guard grant in cycle 16 done");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
